alu_issue_ctrl: RTL
===================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter: TAG_W, 5, width of request/response tag.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: req_valid  input  1  request present.
REQ-005 SHALL have port: req_ready  output  1  request accepted when valid & ready.
REQ-006 SHALL have port: req_funct3  input  3  RISC-V funct3.
REQ-007 SHALL have port: req_funct7b5  input  1  RISC-V funct7 bit 5.
REQ-008 SHALL have port: req_is_imm  input  1  1 = OP-IMM form, B operand taken from req_imm.
REQ-009 SHALL have ports: req_rs1, req_rs2, req_imm  input  32 each  operands.
REQ-010 SHALL have port: req_tag  input  TAG_W  opaque ID echoed on response.
REQ-011 SHALL have ports: alu_a, alu_b  output  32 each  registered ALU operands.
REQ-012 SHALL have port: alu_ctrl  output  2  registered ALU op: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-013 SHALL have port: alu_result  input  32  combinational ALU result for current alu_a/alu_b/alu_ctrl.
REQ-014 SHALL have ports: rsp_valid output 1, rsp_ready input 1  response handshake.
REQ-015 SHALL have ports: rsp_result output 32, rsp_tag output TAG_W, rsp_illegal output 1.

Function
REQ-016 SHALL implement FSM states IDLE, EXEC, RESP; req_ready=1 only in IDLE.
REQ-017 SHALL decode on accept: funct3 000 -> ADD, or SUB when funct7b5=1 and is_imm=0; 111 -> AND; 110 -> OR; every other funct3 -> illegal.
REQ-018 SHALL, on legal accept in IDLE, register alu_a=rs1, alu_b=(is_imm ? imm : rs2), alu_ctrl, tag; go to EXEC.
REQ-019 SHALL in EXEC capture alu_result into rsp_result, go to RESP; rsp_valid rises the cycle after EXEC (accept at edge N, rsp_valid high after edge N+2).
REQ-020 SHALL, on illegal accept, leave alu_* unchanged, set rsp_result=0, rsp_illegal=1, go directly to RESP (rsp_valid high after edge N+1).
REQ-021 SHALL hold rsp_valid, rsp_result, rsp_tag, rsp_illegal stable in RESP until rsp_ready=1, then return to IDLE.
REQ-022 SHALL hold alu_a/alu_b/alu_ctrl at last issued values outside EXEC.
REQ-023 SHALL ignore req_* when req_ready=0; no request lost or duplicated.
REQ-024 SHALL perform arithmetic modulo 2^32; SUB = A + ~B + 1.

Reset
REQ-025 SHALL, while rst_n=0, force state IDLE, rsp_valid=0, rsp_result=0, rsp_tag=0, rsp_illegal=0, alu_a=0, alu_b=0, alu_ctrl=00, flags=0.
REQ-026 SHALL abandon any in-flight operation on reset assertion in any state; no response emitted for it.
REQ-027 SHALL drive req_ready=1 in the first cycle after rst_n deasserts.

Configuration
REQ-028 SHALL, with ALU_ISSUE_FLAGS_EN defined, add outputs rsp_zero, rsp_neg, rsp_carry, rsp_ovf (1 each), captured in EXEC with rsp_result.
REQ-029 SHALL compute flags: zero=(result==0); neg=result[31]; ADD carry=unsigned carry-out, SUB carry=(A>=B unsigned); ovf=signed overflow for ADD/SUB; carry=ovf=0 for AND/OR and illegal.
REQ-030 SHALL, without ALU_ISSUE_FLAGS_EN, omit flag ports and logic entirely; all other behaviour identical.

Verification
REQ-031 SHALL cover: ADD rs1=5, rs2=7, tag=3 -> alu_ctrl=00, rsp_result=12, rsp_tag=3, rsp_valid 2 cycles after accept.
REQ-032 SHALL cover: SUB rs1=0, rs2=1 -> rsp_result=FFFFFFFF; with flags: neg=1, carry=0, ovf=0.
REQ-033 SHALL cover: ORI rs1=F0, imm=0F (funct3=110, is_imm=1, funct7b5=1) -> alu_ctrl=11, rsp_result=FF (no SUB decode for immediate).
REQ-034 SHALL cover: funct3=001 -> rsp_illegal=1, rsp_result=0, rsp_valid 1 cycle after accept, alu_* unchanged.
REQ-035 SHALL cover: rsp_ready held 0 for 4 cycles with req_valid=1 -> req_ready=0 throughout, response stable; release -> IDLE, next request accepted.
REQ-036 SHALL cover: rst_n pulsed low during EXEC -> all outputs per REQ-025 immediately, no response emitted, req_ready=1 after release.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// Module   : alu_issue_ctrl
// Brief    : Single-outstanding issue controller for an external ALU.
//            Decodes ADD/SUB/AND/OR, registers operands, captures the result
//            and holds a tagged response until it is accepted.
//            Optional status flags are enabled with `define ALU_ISSUE_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_ctrl #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_funct3,
    input  logic             req_funct7b5,
    input  logic             req_is_imm,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    input  logic [31:0]      req_imm,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [1:0]       alu_ctrl,
    input  logic [31:0]      alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_illegal
`ifdef ALU_ISSUE_FLAGS_EN
    ,
    output logic             rsp_zero,
    output logic             rsp_neg,
    output logic             rsp_carry,
    output logic             rsp_ovf
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [1:0] C_OP_ADD = 2'b00;
    localparam logic [1:0] C_OP_SUB = 2'b01;
    localparam logic [1:0] C_OP_AND = 2'b10;
    localparam logic [1:0] C_OP_OR  = 2'b11;

    state_t             r_state;
    logic [31:0]        r_alu_a;
    logic [31:0]        r_alu_b;
    logic [1:0]         r_alu_ctrl;
    logic [TAG_W-1:0]   r_tag;
    logic               r_rsp_valid;
    logic [31:0]        r_rsp_result;
    logic [TAG_W-1:0]   r_rsp_tag;
    logic               r_rsp_illegal;

    logic               w_legal;
    logic [1:0]         w_ctrl;
    logic [31:0]        w_opb;

    // Request decode; immediates never decode to SUB regardless of funct7b5.
    always_comb begin
        w_legal = 1'b1;
        w_ctrl  = C_OP_ADD;
        case (req_funct3)
            3'b000:  w_ctrl = (req_funct7b5 && !req_is_imm) ? C_OP_SUB : C_OP_ADD;
            3'b111:  w_ctrl = C_OP_AND;
            3'b110:  w_ctrl = C_OP_OR;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_opb = req_is_imm ? req_imm : req_rs2;

`ifdef ALU_ISSUE_FLAGS_EN
    logic               r_zero;
    logic               r_neg;
    logic               r_carry;
    logic               r_ovf;
    logic [32:0]        w_sum;
    logic [32:0]        w_diff;
    logic               w_carry;
    logic               w_ovf;

    // Carry/overflow come from a local adder on the issued operands so they
    // do not depend on the external ALU exposing its carry chain.
    assign w_sum  = {1'b0, r_alu_a} + {1'b0, r_alu_b};
    assign w_diff = {1'b0, r_alu_a} - {1'b0, r_alu_b};

    always_comb begin
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (r_alu_ctrl)
            C_OP_ADD: begin
                w_carry = w_sum[32];
                w_ovf   = (r_alu_a[31] == r_alu_b[31]) && (w_sum[31] != r_alu_a[31]);
            end
            C_OP_SUB: begin
                w_carry = ~w_diff[32];
                w_ovf   = (r_alu_a[31] != r_alu_b[31]) && (w_diff[31] != r_alu_a[31]);
            end
            default: begin
                w_carry = 1'b0;
                w_ovf   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_zero  <= (alu_result == 32'd0);
            r_neg   <= alu_result[31];
            r_carry <= w_carry;
            r_ovf   <= w_ovf;
        end else if (r_state == S_IDLE && req_valid && !w_legal) begin
            r_zero  <= 1'b1;
            r_neg   <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end
    end

    assign rsp_zero  = r_zero;
    assign rsp_neg   = r_neg;
    assign rsp_carry = r_carry;
    assign rsp_ovf   = r_ovf;
`endif

    // rsp_valid rises one cycle after entering RESP, so the response data
    // is already settled when valid appears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_alu_a       <= 32'd0;
            r_alu_b       <= 32'd0;
            r_alu_ctrl    <= C_OP_ADD;
            r_tag         <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_result  <= 32'd0;
            r_rsp_tag     <= '0;
            r_rsp_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (w_legal) begin
                            r_alu_a    <= req_rs1;
                            r_alu_b    <= w_opb;
                            r_alu_ctrl <= w_ctrl;
                            r_tag      <= req_tag;
                            r_state    <= S_EXEC;
                        end else begin
                            r_rsp_result  <= 32'd0;
                            r_rsp_tag     <= req_tag;
                            r_rsp_illegal <= 1'b1;
                            r_state       <= S_RESP;
                        end
                    end
                end
                S_EXEC: begin
                    r_rsp_result  <= alu_result;
                    r_rsp_tag     <= r_tag;
                    r_rsp_illegal <= 1'b0;
                    r_state       <= S_RESP;
                end
                S_RESP: begin
                    if (!r_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_ctrl    = r_alu_ctrl;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_result  = r_rsp_result;
    assign rsp_tag     = r_rsp_tag;
    assign rsp_illegal = r_rsp_illegal;

endmodule

`default_nettype wire
